fsm3_seq_tracker: RTL and testbench

Registered wrapper and statistics stage for the 4-state "101" Moore recogniser (states A/B/C/D, out in D). It holds the state register with asynchronous reset, advances the state only on qualified input bits, and produces a per-match pulse, a saturating match counter and the stream position of the most recent match. It sits between a serial bit source, which supplies in/in_valid, and a status/CSR consumer.

---
 rtl/fsm3_pkg.sv | 30 +++
 rtl/fsm3_seq_tracker.sv | 102 ++++++++++
 tb/tb_fsm3_seq_tracker.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/fsm3_pkg.sv
// Shared definitions for the "101" Moore recogniser.
// Contents:
//   fsm3_state_t - state encoding, A/B/C/D = 0..3 (D is the match state)
//   fsm3_next    - transition function for one accepted bit
// This is the only place the transition table lives. Every user calls fsm3_next.
package fsm3_pkg;

    typedef enum logic [1:0] {
        ST_A = 2'd0,
        ST_B = 2'd1,
        ST_C = 2'd2,
        ST_D = 2'd3
    } fsm3_state_t;

    // Next state after accepting bit 'in' while in 'state'.
    // D behaves like B on a 1 and like B on a 0. This gives overlapping
    // detection, and it means D never transitions directly back to D.
    function automatic fsm3_state_t fsm3_next(input fsm3_state_t state, input logic in);
        fsm3_state_t nxt;
        case (state)
            ST_A:    nxt = in ? ST_B : ST_A;
            ST_B:    nxt = in ? ST_B : ST_C;
            ST_C:    nxt = in ? ST_D : ST_A;
            ST_D:    nxt = in ? ST_B : ST_C;
            default: nxt = ST_A;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/fsm3_seq_tracker.sv
// Registered "101" recogniser with match statistics.
// Ports:
//   clk          - rising-edge clock
//   areset       - asynchronous active-high reset
//   in           - serial data bit
//   in_valid     - qualifies 'in'; state and statistics hold when low
//   clear        - synchronous clear of state and statistics; takes priority over in_valid
//   state        - current state, A=0 B=1 C=2 D=3
//   out          - Moore output, high while in D (combinational from state)
//   hit          - one-cycle pulse after each entry into D
//   hit_count    - saturating count of entries into D (CW bits)
//   bit_pos      - index of the next bit to be accepted, wraps modulo 2^PW
//   last_hit_pos - bit_pos of the bit that completed the latest match
module fsm3_seq_tracker
    import fsm3_pkg::*;
#(
    parameter int CW = 8,
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          areset,
    input  logic          in,
    input  logic          in_valid,
    input  logic          clear,
    output logic [1:0]    state,
    output logic          out,
    output logic          hit,
    output logic [CW-1:0] hit_count,
    output logic [PW-1:0] bit_pos,
    output logic [PW-1:0] last_hit_pos
);

    localparam logic [CW-1:0] CNT_MAX = '1;

    fsm3_state_t   state_reg, state_next;
    logic          hit_reg, hit_next;
    logic [CW-1:0] count_reg, count_next;
    logic [PW-1:0] pos_reg, pos_next;
    logic [PW-1:0] last_reg, last_next;

    logic          accept;
    logic          match;
    fsm3_state_t   table_next;

    // State and statistics registers
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_reg <= ST_A;
            hit_reg   <= 1'b0;
            count_reg <= '0;
            pos_reg   <= '0;
            last_reg  <= '0;
        end else begin
            state_reg <= state_next;
            hit_reg   <= hit_next;
            count_reg <= count_next;
            pos_reg   <= pos_next;
            last_reg  <= last_next;
        end
    end

    // Next-state and statistics update
    always_comb begin
        accept     = in_valid && !clear;
        table_next = fsm3_next(state_reg, in);
        match      = accept && (table_next == ST_D);

        state_next = state_reg;
        hit_next   = 1'b0;      // hit lasts only one cycle, even while idling in D
        count_next = count_reg;
        pos_next   = pos_reg;
        last_next  = last_reg;

        if (clear) begin
            state_next = ST_A;
            count_next = '0;
            pos_next   = '0;
            last_next  = '0;
        end else if (accept) begin
            state_next = table_next;
            pos_next   = pos_reg + PW'(1);
            if (match) begin
                hit_next  = 1'b1;
                last_next = pos_reg;    // position of the completing bit, before the increment
                if (count_reg != CNT_MAX) begin
                    count_next = count_reg + CW'(1);
                end
            end
        end
    end

    // Outputs
    always_comb begin
        state        = state_reg;
        out          = (state_reg == ST_D);
        hit          = hit_reg;
        hit_count    = count_reg;
        bit_pos      = pos_reg;
        last_hit_pos = last_reg;
    end

endmodule

// File: tb/tb_fsm3_seq_tracker.sv
module tb_fsm3_seq_tracker;

    logic clk = 1'b0;
    logic areset = 1'b1;
    logic in = 1'b0;
    logic in_valid = 1'b0;
    logic clear = 1'b0;

    // Narrow instance (CW=2, PW=3) for saturation and wrap, plus a default instance
    logic [1:0] st_s, st_d;
    logic       out_s, out_d, hit_s, hit_d;
    logic [1:0] cnt_s;
    logic [2:0] pos_s, last_s;
    logic [7:0] cnt_d, pos_d, last_d;

    fsm3_seq_tracker #(.CW(2), .PW(3)) dut_s (
        .clk(clk), .areset(areset), .in(in), .in_valid(in_valid), .clear(clear),
        .state(st_s), .out(out_s), .hit(hit_s), .hit_count(cnt_s),
        .bit_pos(pos_s), .last_hit_pos(last_s)
    );

    fsm3_seq_tracker dut_d (
        .clk(clk), .areset(areset), .in(in), .in_valid(in_valid), .clear(clear),
        .state(st_d), .out(out_d), .hit(hit_d), .hit_count(cnt_d),
        .bit_pos(pos_d), .last_hit_pos(last_d)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference model. It works from the history of accepted bits:
    // D means the last three bits are 1,0,1. B means the last bit is 1.
    // C means the last two bits are 1,0. Anything else is A.
    int          m_len;
    logic [2:0]  m_hist;      // m_hist[0] is the newest accepted bit
    longint      m_matches;
    longint      m_pos;
    longint      m_last;
    logic        m_hit;

    function automatic int m_state();
        if (m_len >= 3 && m_hist == 3'b101) return 3;
        if (m_len >= 1 && m_hist[0]) return 1;
        if (m_len >= 2 && m_hist[1:0] == 2'b10) return 2;
        return 0;
    endfunction

    task automatic model_reset();
        m_len = 0; m_hist = '0; m_matches = 0; m_pos = 0; m_last = 0; m_hit = 1'b0;
    endtask

    task automatic model_edge(input logic b, input logic v, input logic c);
        if (c) begin
            model_reset();
        end else if (v) begin
            m_hist = {m_hist[1:0], b};
            m_len++;
            m_hit = (m_state() == 3);
            if (m_hit) begin
                m_matches++;
                m_last = m_pos;
            end
            m_pos++;
        end else begin
            m_hit = 1'b0;
        end
    endtask

    task automatic check_all(input string tag);
        int s;
        s = m_state();
        chk({tag, "_state_s"}, st_s, s);
        chk({tag, "_out_s"}, out_s, (s == 3) ? 1 : 0);
        chk({tag, "_hit_s"}, hit_s, m_hit);
        chk({tag, "_cnt_s"}, cnt_s, (m_matches > 3) ? 3 : m_matches);
        chk({tag, "_pos_s"}, pos_s, m_pos % 8);
        chk({tag, "_last_s"}, last_s, m_last % 8);
        chk({tag, "_state_d"}, st_d, s);
        chk({tag, "_out_d"}, out_d, (s == 3) ? 1 : 0);
        chk({tag, "_hit_d"}, hit_d, m_hit);
        chk({tag, "_cnt_d"}, cnt_d, (m_matches > 255) ? 255 : m_matches);
        chk({tag, "_pos_d"}, pos_d, m_pos % 256);
        chk({tag, "_last_d"}, last_d, m_last % 256);
    endtask

    // Apply one cycle of inputs; return at edge+1 with the model advanced
    task automatic step(input logic b, input logic v, input logic c);
        in = b; in_valid = v; clear = c;
        @(posedge clk);
        model_edge(b, v, c);
        #1;
    endtask

    // Async reset applied mid-cycle (called at edge+1), released before the next edge
    task automatic mid_reset(input string tag);
        #2;
        areset = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        #1;
        areset = 1'b0;
    endtask

    // Directed vectors, expected values for the narrow instance (CW=2, PW=3)
    typedef struct {
        logic b; logic v; logic c;
        int st; int hit; int cnt; int pos; int last;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic b, input logic v, input logic c,
                       input int st, input int hit, input int cnt, input int pos, input int last);
        vec_t e;
        e.b = b; e.v = v; e.c = c;
        e.st = st; e.hit = hit; e.cnt = cnt; e.pos = pos; e.last = last;
        tbl.push_back(e);
    endtask

    initial begin
        // Overlap 1,0,1,0,1
        add(1,1,0, 1,0,0,1,0);
        add(0,1,0, 2,0,0,2,0);
        add(1,1,0, 3,1,1,3,2);
        add(0,1,0, 2,0,1,4,2);
        add(1,1,0, 3,1,2,5,4);
        // Idle in D with in toggling: hit drops, out stays high
        add(0,0,0, 3,0,2,5,4);
        add(1,0,0, 3,0,2,5,4);
        add(1,1,1, 0,0,0,0,0);
        // Gaps: 1,0,1 with three idle cycles between bits
        add(1,1,0, 1,0,0,1,0);
        for (int k = 0; k < 3; k++) add(k[0] ? 1'b1 : 1'b0, 1'b0, 1'b0, 1,0,0,1,0);
        add(0,1,0, 2,0,0,2,0);
        for (int k = 0; k < 3; k++) add(k[0] ? 1'b0 : 1'b1, 1'b0, 1'b0, 2,0,0,2,0);
        add(1,1,0, 3,1,1,3,2);
        for (int k = 0; k < 3; k++) add(k[0] ? 1'b1 : 1'b0, 1'b0, 1'b0, 3,0,1,3,2);
        // Reach C, then clear with a valid 1 that would otherwise complete a match
        add(0,1,0, 2,0,1,4,2);
        add(1,1,1, 0,0,0,0,0);
        // Saturation: 1,0,1,0,... gives seven matches; counter sticks at 3, position wraps
        for (int k = 0; k < 15; k++) begin
            int st, cnt, last;
            st   = (k == 0) ? 1 : ((k % 2) ? 2 : 3);
            cnt  = (k / 2 > 3) ? 3 : k / 2;
            last = (k >= 2) ? (((k % 2) ? k - 1 : k) % 8) : 0;
            add((k % 2 == 0) ? 1'b1 : 1'b0, 1'b1, 1'b0, st, (k >= 2 && k % 2 == 0) ? 1 : 0,
                cnt, (k + 1) % 8, last);
        end
        add(0,1,1, 0,0,0,0,0);
        // Wrap: seven zeros, then 1,0,1 - the match on the 10th bit sits at wrapped index 1
        for (int k = 0; k < 7; k++) add(0,1,0, 0,0,0,k + 1,0);
        add(1,1,0, 1,0,0,0,0);
        add(0,1,0, 2,0,0,1,0);
        add(1,1,0, 3,1,1,2,1);

        // Reset state while areset is held
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        areset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].b, tbl[i].v, tbl[i].c);
            chk($sformatf("v%0d_state", i), st_s, tbl[i].st);
            chk($sformatf("v%0d_out", i), out_s, (tbl[i].st == 3) ? 1 : 0);
            chk($sformatf("v%0d_hit", i), hit_s, tbl[i].hit);
            chk($sformatf("v%0d_cnt", i), cnt_s, tbl[i].cnt);
            chk($sformatf("v%0d_pos", i), pos_s, tbl[i].pos);
            chk($sformatf("v%0d_last", i), last_s, tbl[i].last);
            chk($sformatf("v%0d_state_d", i), st_d, tbl[i].st);
            chk($sformatf("v%0d_hit_d", i), hit_d, tbl[i].hit);
        end

        // Mid-cycle reset during a partial match: the next 1 must not complete it
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("pre_reset_state", st_s, 2);
        mid_reset("midreset");
        step(1'b1, 1'b1, 1'b0);
        chk("post_reset_state", st_s, 1);
        chk("post_reset_hit", hit_s, 0);
        chk("post_reset_cnt", cnt_d, 0);

        // Random traffic with occasional clear and async reset
        step(1'b0, 1'b0, 1'b1);
        for (int n = 0; n < 2000; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r == 0) begin
                mid_reset($sformatf("r%0d_areset", n));
            end else begin
                step(1'($urandom), ($urandom_range(0, 99) < 75) ? 1'b1 : 1'b0, (r < 3) ? 1'b1 : 1'b0);
                check_all($sformatf("r%0d", n));
            end
        end

        // Dense 1,0 stream with random gaps, driving the default counter into saturation
        step(1'b0, 1'b0, 1'b1);
        for (int n = 0; n < 800; n++) begin
            logic v;
            v = ($urandom_range(0, 99) < 80) ? 1'b1 : 1'b0;
            step((m_pos % 2 == 0) ? 1'b1 : 1'b0, v, 1'b0);
            check_all($sformatf("s%0d", n));
        end
        chk("final_cnt_d_saturated", cnt_d, 255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
